// File: rtl/auth_pwr_ctrl.sv
// auth_pwr_ctrl: authentication and power-enable controller.
// Consumes UART bytes, drives pwr_up from configurable start/stop codes,
// applies a rider-off grace delay and counts unrecognised bytes.
// Optional link-loss timeout is compiled in with `define AUTH_TIMEOUT_EN.
module auth_pwr_ctrl #(
   parameter logic [7:0]  ON_CODE   = 8'h67,
   parameter logic [7:0]  STOP_CODE = 8'h73,
   parameter int unsigned OFF_DLY   = 50_000,
   parameter int unsigned TIMEOUT   = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rider_off,
   input  logic [7:0] rx_data,
   input  logic       rx_rdy,
   output logic       clr_rx_rdy,
   output logic       pwr_up,
   output logic [7:0] err_cnt,
   output logic       link_lost
);

   localparam logic [1:0] S_OFF      = 2'd0;
   localparam logic [1:0] S_RUN      = 2'd1;
   localparam logic [1:0] S_STOP_REQ = 2'd2;
   localparam logic [1:0] S_GRACE    = 2'd3;

   // Keep the delay counter at least one bit wide so OFF_DLY=0 still elaborates.
   localparam int unsigned DW = (OFF_DLY > 0) ? $clog2(OFF_DLY + 1) : 1;
   localparam logic [DW-1:0] DLY_LAST = (OFF_DLY > 0) ? DW'(OFF_DLY - 1) : '0;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] dly_q, dly_d;
   logic [7:0]    err_q;
   logic          pwr_q;
   logic          is_on, is_stop, is_err;
   logic          timeout_hit;

   assign clr_rx_rdy = rx_rdy;
   assign is_on      = rx_rdy && (rx_data == ON_CODE);
   assign is_stop    = rx_rdy && (rx_data == STOP_CODE);
   assign is_err     = rx_rdy && !is_on && !is_stop;

`ifdef AUTH_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] IDLE_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   logic [TW-1:0] idle_q;
   logic          ll_q;

   // Any byte in the expiry cycle wins over the timeout.
   assign timeout_hit = (state_q == S_RUN) && !rx_rdy && (idle_q == IDLE_LAST);
   assign link_lost   = ll_q;

   // Idle counter counts silent RUN cycles; held at 0 elsewhere.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= '0;
         ll_q   <= 1'b0;
      end else begin
         if ((state_q == S_RUN) && (state_d == S_RUN) && !rx_rdy) begin
            idle_q <= idle_q + 1'b1;
         end else begin
            idle_q <= '0;
         end
         if (is_on) begin
            ll_q <= 1'b0;
         end else if (timeout_hit) begin
            ll_q <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign link_lost   = 1'b0;
`endif

   // Next-state and grace-delay counter logic.
   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      case (state_q)
         S_OFF: begin
            if (is_on) state_d = S_RUN;
         end
         S_RUN: begin
            if (is_stop) begin
               state_d = rider_off ? S_OFF : S_STOP_REQ;
            end else if (timeout_hit) begin
               state_d = S_STOP_REQ;
            end
         end
         S_STOP_REQ: begin
            if (is_on) begin
               state_d = S_RUN;
            end else if (rider_off) begin
               dly_d = '0;
               if (OFF_DLY == 0) begin
                  state_d = S_OFF;
               end else begin
                  state_d = S_GRACE;
               end
            end
         end
         S_GRACE: begin
            if (is_on) begin
               state_d = S_RUN;
               dly_d   = '0;
            end else if (!rider_off) begin
               state_d = S_STOP_REQ;
               dly_d   = '0;
            end else if (dly_q == DLY_LAST) begin
               state_d = S_OFF;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         default: begin
            state_d = S_OFF;
            dly_d   = '0;
         end
      endcase
   end

   // State, power enable and saturating error counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_OFF;
         dly_q   <= '0;
         err_q   <= 8'h00;
         pwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dly_q   <= dly_d;
         pwr_q   <= (state_d != S_OFF);
         if (is_err && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'h01;
         end
      end
   end

   assign pwr_up  = pwr_q;
   assign err_cnt = err_q;

endmodule

// File: tb/tb_auth_pwr_ctrl.sv
// Scoreboard bench for auth_pwr_ctrl with OFF_DLY=4 and TIMEOUT=10.
module tb_auth_pwr_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       rider_off;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       clr_rx_rdy;
   logic       pwr_up;
   logic [7:0] err_cnt;
   logic       link_lost;

   int total = 0;
   int bad   = 0;

`ifdef AUTH_TIMEOUT_EN
   localparam bit TmoEn = 1'b1;
`else
   localparam bit TmoEn = 1'b0;
`endif

   typedef struct {
      logic       clr;
      logic       pwr;
      logic [7:0] err;
      logic       ll;
   } exp_t;

   exp_t exp_q[$];

   auth_pwr_ctrl #(
      .ON_CODE   (8'h67),
      .STOP_CODE (8'h73),
      .OFF_DLY   (4),
      .TIMEOUT   (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rider_off  (rider_off),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .clr_rx_rdy (clr_rx_rdy),
      .pwr_up     (pwr_up),
      .err_cnt    (err_cnt),
      .link_lost  (link_lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Apply one cycle of stimulus and queue the hand-computed post-edge response.
   task automatic step(input logic r, input logic rdy, input logic [7:0] d, input logic roff,
                       input logic ep, input logic [7:0] ee, input logic el);
      exp_t e;
      @(posedge clk);
      #2;
      rst       = r;
      rx_rdy    = rdy;
      rx_data   = d;
      rider_off = roff;
      e.clr = rdy;
      e.pwr = ep;
      e.err = ee;
      e.ll  = el;
      exp_q.push_back(e);
   endtask

   // Monitor: clr_rx_rdy mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("clr_rx_rdy", {7'd0, clr_rx_rdy}, {7'd0, e.clr});
            @(posedge clk);
            #1;
            chk("pwr_up", {7'd0, pwr_up}, {7'd0, e.pwr});
            chk("err_cnt", err_cnt, e.err);
            chk("link_lost", {7'd0, link_lost}, {7'd0, e.ll});
         end
      end
   end

   initial begin
      rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rider_off = 1'b0;

      // Reset, including a byte during reset (consumed, not counted).
      step(1, 0, 8'h00, 0, 0, 8'h00, 0);
      step(1, 1, 8'h41, 0, 0, 8'h00, 0);

      // Power up, then stop request with rider present.
      step(0, 1, 8'h67, 0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0, 1, 8'h00, 0);
      step(0, 1, 8'h73, 0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0, 1, 8'h00, 0);

      // Rider leaves: pwr_up falls on the 5th sampled-high cycle.
      for (int i = 1; i <= 5; i++) step(0, 0, 8'h00, 1, (i < 5), 8'h00, 0);

      // Grace interrupted at count 2, then full delay restarts.
      step(0, 1, 8'h67, 0, 1, 8'h00, 0);
      step(0, 1, 8'h73, 0, 1, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0, 1, 8'h00, 0);
      for (int i = 1; i <= 5; i++) step(0, 0, 8'h00, 1, (i < 5), 8'h00, 0);

      // ON_CODE in the grace-expiry cycle wins.
      step(0, 1, 8'h67, 0, 1, 8'h00, 0);
      step(0, 1, 8'h73, 0, 1, 8'h00, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 1, 8'h00, 0);
      step(0, 1, 8'h67, 1, 1, 8'h00, 0);
      step(0, 0, 8'h00, 1, 1, 8'h00, 0);
      // STOP_CODE in RUN with rider absent: immediate off.
      step(0, 1, 8'h73, 1, 0, 8'h00, 0);

      // Error counter saturation while off; STOP_CODE ignored.
      for (int i = 1; i <= 300; i++) begin
         step(0, 1, 8'h41, 0, 0, (i < 255) ? 8'(i) : 8'hFF, 0);
      end
      step(0, 1, 8'h73, 0, 0, 8'hFF, 0);
      step(0, 0, 8'h00, 0, 0, 8'hFF, 0);
      step(0, 1, 8'h67, 0, 1, 8'hFF, 0);

      // Silent link: forced stop request after 10 idle cycles when enabled.
      for (int j = 1; j <= 10; j++) step(0, 0, 8'h00, 0, 1, 8'hFF, TmoEn && (j >= 10));
      step(0, 0, 8'h00, 0, 1, 8'hFF, TmoEn);
      step(0, 1, 8'h67, 0, 1, 8'hFF, 0);
      step(0, 0, 8'h00, 0, 1, 8'hFF, 0);
      step(0, 1, 8'h73, 1, 0, 8'hFF, 0);

      // Mid-operation reset clears everything.
      step(0, 1, 8'h67, 0, 1, 8'hFF, 0);
      step(1, 1, 8'h41, 0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 0, 0, 8'h00, 0);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #3;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/auth_pwr_ctrl.md
# auth_pwr_ctrl

Parametrised authentication and power-enable controller for the Segway, successor to the fixed 'g'/'s' authentication block. It consumes bytes from an external `uart_rx` through its `rx_data`/`rdy`/`clr_rdy` handshake. It drives `pwr_up` to the rest of the design using configurable start/stop codes, a rider-off grace delay, and a diagnostic count of unrecognised bytes. An optional link-loss timeout, compiled in by macro, converts a silent BLE link into a stop request.

## Interface
- `ON_CODE`, default 8'h67: byte that authorises power-up, and also keeps power on or re-arms.
- `STOP_CODE`, default 8'h73: byte that requests shutdown.
- `OFF_DLY`, default 50_000: number of consecutive `rider_off` cycles required before shutdown after a stop request; 0 means immediate.
- `TIMEOUT`, default 25_000_000: idle-link cycles before a forced stop request; only used under `AUTH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `rider_off`  in  1  rider absent, from the load-cell logic.
- `rx_data`  in  8  byte from `uart_rx`.
- `rx_rdy`  in  1  `rx_data` valid; held high until cleared.
- `clr_rx_rdy`  out  1  combinational pulse that consumes the current byte.
- `pwr_up`  out  1  registered power enable.
- `err_cnt`  out  8  saturating count of bytes that are neither `ON_CODE` nor `STOP_CODE`.
- `link_lost`  out  1  sticky link-timeout flag; constant 0 without the macro.

## Operation
- States: OFF, RUN, STOP_REQ, GRACE. Reset puts the block in OFF with `pwr_up`=0, `err_cnt`=0, `link_lost`=0, and both counters at 0.
- Byte consumption:
  - `clr_rx_rdy` equals `rx_rdy` in every state, so every byte is consumed in its arrival cycle.
  - A byte matching neither code increments `err_cnt`, which saturates at 8'hFF. It causes no state change.
- OFF:
  - `ON_CODE` → RUN.
  - `STOP_CODE` is ignored. It is consumed and not counted as an error.
- RUN:
  - `STOP_CODE` with `rider_off`=1 → OFF.
  - `STOP_CODE` with `rider_off`=0 → STOP_REQ.
  - `ON_CODE` → stay in RUN.
- STOP_REQ:
  - `ON_CODE` → RUN.
  - Otherwise, if `rider_off`=1: go to OFF when `OFF_DLY`=0, else to GRACE with the delay counter loaded to 0.
- GRACE, with priority in this order:
  1. `ON_CODE` → RUN.
  2. `rider_off`=0 → STOP_REQ, and the counter is cleared.
  3. Counter = `OFF_DLY`-1 → OFF.
  4. Otherwise the counter increments.
- `pwr_up` = (next state ≠ OFF), registered. It is therefore 1 in RUN, STOP_REQ and GRACE.
- Delay counter width is `$clog2(OFF_DLY+1)`. It never wraps; it is only loaded or cleared on GRACE entry or exit.
- A byte arriving in the same cycle as delay expiry follows the priority order above, so `ON_CODE` wins over expiry.

## Timing
- A byte accepted in cycle N gives the new state and `pwr_up` in cycle N+1. `clr_rx_rdy` is high in cycle N.
- STOP_REQ with `rider_off` held high: GRACE is entered at N+1, OFF at N+1+`OFF_DLY`, and `pwr_up` falls in that same cycle.
- `err_cnt` updates one cycle after the offending byte.
- `rst` asserted mid-operation takes effect at the next edge: state OFF, `pwr_up`=0, all counters cleared. `clr_rx_rdy` is still driven from `rx_rdy` during reset.

## Configuration
- `AUTH_TIMEOUT_EN` defined:
  - An idle counter, `$clog2(TIMEOUT+1)` bits wide, runs in RUN and is cleared by any accepted byte.
  - When it reaches `TIMEOUT`-1, the block forces RUN → STOP_REQ as if `STOP_CODE` had been received, and sets `link_lost`=1.
  - `link_lost` clears on the next accepted `ON_CODE` or on `rst`.
  - The idle counter is held at 0 outside RUN.
  - A byte arriving in the expiry cycle takes precedence over the timeout.
- `AUTH_TIMEOUT_EN` undefined: no idle counter is built, `link_lost` is tied to 0, and RUN never exits without `STOP_CODE`.

## Test plan
- Reset, then byte 8'h67 with `rider_off`=0 → `clr_rx_rdy` pulses in the same cycle; next cycle state is RUN, `pwr_up`=1, `err_cnt`=0.
- RUN, `rider_off`=0, byte 8'h73 → STOP_REQ, `pwr_up` stays 1. Then raise `rider_off` with `OFF_DLY`=4 → `pwr_up` falls exactly 5 cycles after `rider_off` is sampled high.
- GRACE at count 2, drop `rider_off` for 1 cycle → return to STOP_REQ. Re-raising `rider_off` restarts the full 4-cycle delay.
- GRACE at count `OFF_DLY`-1 with byte 8'h67 in the same cycle → RUN, `pwr_up` never deasserts.
- OFF, send 300 bytes of 8'h41 → `err_cnt`=8'hFF with `pwr_up`=0 throughout. Then 8'h73 → no change.
- With `AUTH_TIMEOUT_EN` and `TIMEOUT`=10: RUN with no bytes for 10 cycles → STOP_REQ, `link_lost`=1, `pwr_up`=1. Then 8'h67 → RUN, `link_lost`=0.
